// File: rtl/alu_pkg.sv
// Shared constants for the ALU sequencer: opcodes, instruction fields, FSM states.
package alu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_LDB  = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_DIV  = 4'h4;
  localparam logic [3:0] OP_SHL  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_ADD  = 4'h7;
  localparam logic [3:0] OP_SUB  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Opcode occupies the upper nibble of the instruction byte; lower nibble is ignored.
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT,
    S_ERR
  } seqState_t;

  // True for opcodes that are handed to the ALU (LDA..SUB).
  function automatic logic isAluOp(input logic [3:0] op);
    return (op >= OP_LDA) && (op <= OP_SUB);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Program RAM and ALU handshake bundle; master side is the sequencer.
interface alu_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_data;
  logic [3:0]        alu_op;
  logic              alu_start;
  logic              alu_done;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_comp;

  modport master (
    output mem_addr, mem_rd, alu_op, alu_start,
    input  mem_data, alu_done, alu_result, alu_carry, alu_comp
  );

  modport slave (
    input  mem_addr, mem_rd, alu_op, alu_start,
    output mem_data, alu_done, alu_result, alu_carry, alu_comp
  );

endinterface

// File: rtl/alu_seq_watchdog.sv
// Counts cycles spent waiting on the ALU and flags when the budget is used up.
module alu_seq_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  // Count enabled cycles; hold once the limit is reached so the flag stays up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !timeout) begin
      count <= count + CNT_W'(1);
    end
  end

  assign timeout = (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/alu_sequencer.sv
// ALU control unit: fetch/decode program bytes, launch ALU ops, write back results.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int ALU_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_addr,
  alu_sequencer_if.master     bus,
  output logic [DATA_W-1:0]   result,
  output logic                carry_flag,
  output logic                comp_flag,
  output logic                busy,
  output logic                halted,
  output logic                error
);

  seqState_t         state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pcNext;
  logic [7:0]        ir;
  logic [3:0]        irOp;
  logic              wdClear;
  logic              wdEnable;
  logic              wdTimeout;
  logic              unusedIrLow;

  assign pcNext      = pc + ADDR_W'(1);
  assign irOp        = ir[OPC_MSB:OPC_LSB];
  assign unusedIrLow = ^ir[OPC_LSB-1:0];
  assign wdClear     = (state != S_EXEC);
  assign wdEnable    = (state == S_EXEC);

  alu_seq_watchdog #(
    .TIMEOUT(ALU_TIMEOUT)
  ) uWatchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wdClear),
    .enable (wdEnable),
    .timeout(wdTimeout)
  );

  // Sequencer FSM with registered outputs. mem_addr/mem_rd are loaded on the
  // transition into FETCH so the read is presented during FETCH itself and the
  // byte arrives in WAIT. The ALU result is latched on the alu_done cycle (the
  // only cycle it is guaranteed valid); WB then only advances the pc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      pc            <= '0;
      ir            <= '0;
      bus.mem_addr  <= '0;
      bus.mem_rd    <= 1'b0;
      bus.alu_op    <= '0;
      bus.alu_start <= 1'b0;
      result        <= '0;
      carry_flag    <= 1'b0;
      comp_flag     <= 1'b0;
      busy          <= 1'b0;
      halted        <= 1'b0;
      error         <= 1'b0;
    end else begin
      bus.mem_rd    <= 1'b0;
      bus.alu_start <= 1'b0;
      case (state)
        S_IDLE, S_HALT, S_ERR: begin
          if (start) begin
            pc           <= start_addr;
            bus.mem_addr <= start_addr;
            bus.mem_rd   <= 1'b1;
            busy         <= 1'b1;
            halted       <= 1'b0;
            error        <= 1'b0;
            state        <= S_FETCH;
          end
        end
        S_FETCH: begin
          bus.mem_addr <= pc;
          state        <= S_WAIT;
        end
        S_WAIT: begin
          ir    <= bus.mem_data;
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (irOp == OP_NOP) begin
            pc           <= pcNext;
            bus.mem_addr <= pcNext;
            bus.mem_rd   <= 1'b1;
            state        <= S_FETCH;
          end else if (irOp == OP_HALT) begin
            busy   <= 1'b0;
            halted <= 1'b1;
            state  <= S_HALT;
          end else if (isAluOp(irOp)) begin
            bus.alu_op    <= irOp;
            bus.alu_start <= 1'b1;
            state         <= S_EXEC;
          end else begin
            busy  <= 1'b0;
            error <= 1'b1;
            state <= S_ERR;
          end
        end
        S_EXEC: begin
          // A done coinciding with our own start pulse is stale and ignored.
          if (bus.alu_done && !bus.alu_start) begin
            result <= bus.alu_result;
            if (bus.alu_op == OP_ADD) carry_flag <= bus.alu_carry;
            if (bus.alu_op == OP_SUB) comp_flag  <= bus.alu_comp;
            state <= S_WB;
          end else if (wdTimeout) begin
            busy  <= 1'b0;
            error <= 1'b1;
            state <= S_ERR;
          end
        end
        S_WB: begin
          pc           <= pcNext;
          bus.mem_addr <= pcNext;
          bus.mem_rd   <= 1'b1;
          state        <= S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed cases plus random programs
// checked against an instruction-level interpreter of the program RAM.
module tb_alu_sequencer;

  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 8;
  localparam int ALU_TIMEOUT = 15;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] res;
    logic       c;
    logic       n;
  } done_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] start_addr = '0;
  logic [7:0] result;
  logic       carry_flag, comp_flag, busy, halted, error;

  int vectors = 0;
  int miscompares = 0;

  // Environment models
  logic [7:0] prog [256];
  int         aluCnt = 0;
  int         aluForceDelay = 0;
  int         startCount = 0;
  bit         aluMute = 1'b0;
  bit         forceVals = 1'b0;
  logic [7:0] fRes = '0;
  logic       fC = 1'b0, fN = 1'b0;
  logic [7:0] rRes;
  logic       rC, rN;
  logic [3:0] opsSeen [$];
  done_t      doneLog [$];

  // Reference model state
  logic [3:0] expOps [$];
  logic       expHalt, expErr;
  logic [7:0] expPc;
  logic [7:0] mResult = '0;
  logic       mCarry = 1'b0, mComp = 1'b0;

  alu_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  alu_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ALU_TIMEOUT(ALU_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .bus(bus),
    .result(result), .carry_flag(carry_flag), .comp_flag(comp_flag),
    .busy(busy), .halted(halted), .error(error)
  );

  always #5 clk = ~clk;

  // Synchronous program RAM: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_data <= prog[bus.mem_addr];
  end

  // ALU stand-in: answers each start after a random delay; junk on the result bus otherwise.
  always @(posedge clk) begin
    if (aluCnt == 1) begin
      if (forceVals) begin
        rRes = fRes; rC = fC; rN = fN;
      end else begin
        rRes = 8'($urandom); rC = 1'($urandom_range(0, 1)); rN = 1'($urandom_range(0, 1));
      end
      bus.alu_done   <= 1'b1;
      bus.alu_result <= rRes;
      bus.alu_carry  <= rC;
      bus.alu_comp   <= rN;
      doneLog.push_back('{bus.alu_op, rRes, rC, rN});
    end else begin
      bus.alu_done   <= 1'b0;
      bus.alu_result <= 8'($urandom);
      bus.alu_carry  <= 1'($urandom_range(0, 1));
      bus.alu_comp   <= 1'($urandom_range(0, 1));
    end
    if (aluCnt > 0) aluCnt = aluCnt - 1;
    if (bus.alu_start === 1'b1) begin
      startCount++;
      opsSeen.push_back(bus.alu_op);
      if (!aluMute) aluCnt = (aluForceDelay > 0) ? aluForceDelay : int'($urandom_range(1, 6));
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Interpret the program from addr: which ALU ops run, and how it ends.
  task automatic modelRun(input logic [7:0] addr);
    logic [7:0] p;
    logic [7:0] b;
    logic [3:0] op;
    expOps.delete();
    expHalt = 1'b0;
    expErr  = 1'b0;
    p = addr;
    for (int s = 0; s < 512; s++) begin
      b  = prog[p];
      op = b[7:4];
      if (op == 4'h0) begin
        p = p + 8'd1;
      end else if (op == 4'hF) begin
        expHalt = 1'b1;
        break;
      end else if (op <= 4'h8) begin
        expOps.push_back(op);
        p = p + 8'd1;
      end else begin
        expErr = 1'b1;
        break;
      end
    end
    expPc = p;
  endtask

  task automatic checkModel(input logic [7:0] addr);
    int n;
    modelRun(addr);
    check("op_count", opsSeen.size(), expOps.size());
    check("done_count", doneLog.size(), expOps.size());
    n = (doneLog.size() < expOps.size()) ? doneLog.size() : expOps.size();
    for (int i = 0; i < n; i++) begin
      check("op_at_start", opsSeen[i], expOps[i]);
      check("op_at_done", doneLog[i].op, expOps[i]);
      mResult = doneLog[i].res;
      if (expOps[i] == 4'h7) mCarry = doneLog[i].c;
      if (expOps[i] == 4'h8) mComp  = doneLog[i].n;
    end
    check("halted", halted, expHalt);
    check("error", error, expErr);
    check("pc", bus.mem_addr, expPc);
    check("result", result, mResult);
    check("carry_flag", carry_flag, mCarry);
    check("comp_flag", comp_flag, mComp);
  endtask

  // Start at addr (holding start into FETCH with another address, which must be ignored),
  // then wait for the sequencer to stop.
  task automatic runProg(input logic [7:0] addr);
    opsSeen.delete();
    doneLog.delete();
    startCount = 0;
    @(negedge clk);
    start_addr = addr;
    start = 1'b1;
    @(negedge clk);
    check("busy_after_start", busy, 1'b1);
    check("error_after_start", error, 1'b0);
    check("halted_after_start", halted, 1'b0);
    start_addr = 8'($urandom);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check("run_finished", busy, 1'b0);
  endtask

  initial begin
    logic [7:0] base;
    logic [7:0] a;
    logic [3:0] op;
    int         n;
    int         cnt;
    bit         found;

    for (int i = 0; i < 256; i++) prog[i] = 8'hF0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 8'h00);
    check("rst_mem_rd", bus.mem_rd, 1'b0);
    check("rst_alu_start", bus.alu_start, 1'b0);
    check("rst_result", result, 8'h00);
    check("rst_flags", {carry_flag, comp_flag}, 2'b00);
    rst = 1'b0;

    // ADD then HALT
    prog[8'h00] = 8'h70;
    prog[8'h01] = 8'hF0;
    forceVals = 1'b1; fRes = 8'h2A; fC = 1'b1; fN = 1'b1;
    runProg(8'h00);
    checkModel(8'h00);
    check("t1_result", result, 8'h2A);
    check("t1_carry", carry_flag, 1'b1);
    check("t1_comp_untouched", comp_flag, 1'b0);
    check("t1_pc", bus.mem_addr, 8'h01);
    check("t1_starts", startCount, 1);

    // SUB after ADD: comp updates, carry holds
    prog[8'h10] = 8'h81;
    prog[8'h11] = 8'hF3;
    fRes = 8'h05; fC = 1'b0; fN = 1'b1;
    runProg(8'h10);
    checkModel(8'h10);
    check("t2_comp", comp_flag, 1'b1);
    check("t2_carry_held", carry_flag, 1'b1);
    forceVals = 1'b0;

    // Illegal opcode, then restart out of ERR
    prog[8'h20] = 8'h90;
    runProg(8'h20);
    checkModel(8'h20);
    check("t3_no_alu_start", startCount, 0);
    runProg(8'h20);
    checkModel(8'h20);

    // ALU never answers: error after ALU_TIMEOUT+1 EXEC cycles
    prog[8'h30] = 8'h3C;
    aluMute = 1'b1;
    opsSeen.delete(); doneLog.delete(); startCount = 0;
    @(negedge clk); start_addr = 8'h30; start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.alu_start === 1'b1) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("t4_start_seen", found, 1'b1);
    cnt = 0;
    while (cnt < 40 && error !== 1'b1) begin
      @(negedge clk);
      cnt++;
    end
    check("t4_exec_cycles", cnt, ALU_TIMEOUT + 1);
    check("t4_error", error, 1'b1);
    check("t4_busy", busy, 1'b0);
    check("t4_starts", startCount, 1);
    check("t4_result_kept", result, mResult);
    aluMute = 1'b0;

    // pc wraps from 0xFF to 0x00
    prog[8'hFF] = 8'h07;
    prog[8'h00] = 8'hF0;
    runProg(8'hFF);
    checkModel(8'hFF);
    check("t5_pc_wrap", bus.mem_addr, 8'h00);

    // Reset during EXEC, ALU answers after release
    prog[8'h40] = 8'h50;
    aluForceDelay = 8;
    @(negedge clk); start_addr = 8'h40; start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.alu_start === 1'b1) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("t6_start_seen", found, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("t6_busy", busy, 1'b0);
    check("t6_halted", halted, 1'b0);
    check("t6_error", error, 1'b0);
    check("t6_result", result, 8'h00);
    check("t6_flags", {carry_flag, comp_flag}, 2'b00);
    check("t6_mem_addr", bus.mem_addr, 8'h00);
    check("t6_strobes", {bus.mem_rd, bus.alu_start}, 2'b00);
    mResult = '0; mCarry = 1'b0; mComp = 1'b0;
    aluForceDelay = 0;

    // Random programs
    for (int t = 0; t < 24; t++) begin
      base = 8'($urandom);
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        a = base + 8'(k);
        if ($urandom_range(0, 99) < 6) op = 4'($urandom_range(9, 14));
        else op = 4'($urandom_range(0, 8));
        prog[a] = {op, 4'($urandom)};
      end
      a = base + 8'(n);
      prog[a] = {4'hF, 4'($urandom)};
      runProg(base);
      checkModel(base);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
